// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Passes non-memory results through to write-back with one cycle of latency.
// Runs one req/ack data-bus transaction per aligned load or store, and
// extends the returned load data into the write-back word. Misaligned
// accesses are flagged and never reach the bus.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   valid_i, wd_i, wreg_i,         execute-stage instruction: destination,
//   wdata_i, mem_op_i,             ALU result/effective address, memory op,
//   mem_wdata_i                    and store operand
//   stall_o                        hold upstream (only combinational output)
//   dbus_req_o, dbus_we_o,         registered data-bus request
//   dbus_addr_o, dbus_be_o,
//   dbus_wdata_o
//   dbus_rdata_i, dbus_ack_i       bus response (rdata valid in ack cycle)
//   wb_valid_o, wb_wd_o,           registered write-back triple
//   wb_wreg_o, wb_wdata_o
//   misalign_o, badvaddr_o         misaligned-access flag and its address
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        misalign_o,
    output logic [31:0] badvaddr_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state, state_next;

    // Instruction captured at accept time for use when the ack returns.
    logic [3:0]  op_q;
    logic [1:0]  lo_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    // Decode of the incoming instruction.
    logic        is_mem;
    logic        is_store;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic        accept;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        mis      = 1'b0;
        be       = '0;
        st_data  = '0;
        case (mem_op_i)
            OP_LB, OP_LBU: begin
                is_mem = 1'b1;
                be     = 4'b0001 << wdata_i[1:0];
            end
            OP_LH, OP_LHU: begin
                is_mem = 1'b1;
                mis    = wdata_i[0];
                be     = wdata_i[1] ? 4'b1100 : 4'b0011;
            end
            OP_LW: begin
                is_mem = 1'b1;
                mis    = |wdata_i[1:0];
                be     = 4'b1111;
            end
            OP_SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                be       = 4'b0001 << wdata_i[1:0];
                st_data  = {4{mem_wdata_i[7:0]}};
            end
            OP_SH: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                mis      = wdata_i[0];
                be       = wdata_i[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{mem_wdata_i[15:0]}};
            end
            OP_SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                mis      = |wdata_i[1:0];
                be       = 4'b1111;
                st_data  = mem_wdata_i;
            end
            default: ;
        endcase
    end

    assign accept = (state == IDLE) && valid_i && is_mem && !mis;

    // Load alignment: little-endian lane selection from the captured offset.
    always_comb begin
        ld_byte = '0;
        case (lo_q)
            2'd0: ld_byte = dbus_rdata_i[7:0];
            2'd1: ld_byte = dbus_rdata_i[15:8];
            2'd2: ld_byte = dbus_rdata_i[23:16];
            2'd3: ld_byte = dbus_rdata_i[31:24];
            default: ;
        endcase
        ld_half = lo_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        ld_data = '0;
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            OP_LW:   ld_data = dbus_rdata_i;
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // stall_o drops in the ack cycle so upstream advances on that same edge.
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUS;
                    stall_o    = 1'b1;
                end
            end
            BUS: begin
                stall_o = ~dbus_ack_i;
                if (dbus_ack_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            lo_q         <= '0;
            wd_q         <= '0;
            wreg_q       <= 1'b0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_wd_o      <= '0;
            wb_wreg_o    <= 1'b0;
            wb_wdata_o   <= '0;
            misalign_o   <= 1'b0;
            badvaddr_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid_o <= 1'b0;
                    wb_wreg_o  <= 1'b0;
                    misalign_o <= 1'b0;
                    if (valid_i) begin
                        if (!is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_wd_o    <= wd_i;
                            wb_wreg_o  <= wreg_i;
                            wb_wdata_o <= wdata_i;
                        end else if (mis) begin
                            wb_valid_o <= 1'b1;
                            wb_wd_o    <= wd_i;
                            wb_wdata_o <= '0;
                            misalign_o <= 1'b1;
                            badvaddr_o <= wdata_i;
                        end else begin
                            op_q         <= mem_op_i;
                            lo_q         <= wdata_i[1:0];
                            wd_q         <= wd_i;
                            wreg_q       <= wreg_i;
                            dbus_req_o   <= 1'b1;
                            dbus_we_o    <= is_store;
                            dbus_addr_o  <= {wdata_i[31:2], 2'b00};
                            dbus_be_o    <= be;
                            dbus_wdata_o <= st_data;
                        end
                    end
                end
                BUS: begin
                    wb_valid_o <= 1'b0;
                    misalign_o <= 1'b0;
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_wd_o    <= wd_q;
                        // dbus_we_o still marks the finished access as a store.
                        wb_wreg_o  <= dbus_we_o ? 1'b0 : wreg_q;
                        wb_wdata_o <= ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic [31:0] dbus_rdata_i = '0;
    logic        dbus_ack_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        misalign_o;
    logic [31:0] badvaddr_o;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_op_i     (mem_op_i),
        .mem_wdata_i  (mem_wdata_i),
        .stall_o      (stall_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_ack_i   (dbus_ack_i),
        .wb_valid_o   (wb_valid_o),
        .wb_wd_o      (wb_wd_o),
        .wb_wreg_o    (wb_wreg_o),
        .wb_wdata_o   (wb_wdata_o),
        .misalign_o   (misalign_o),
        .badvaddr_o   (badvaddr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        mis;
        logic [31:0] bad;
        bit          chk_wd;
        bit          chk_wdata;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write-back presented by the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got wb_valid_o=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_cycle", cyc, e.cyc);
                chk("wb_wreg", {31'd0, wb_wreg_o}, {31'd0, e.wreg});
                chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
                if (e.mis) chk("badvaddr", badvaddr_o, e.bad);
                if (e.chk_wd) chk("wb_wd", {27'd0, wb_wd_o}, {27'd0, e.wd});
                if (e.chk_wdata) chk("wb_wdata", wb_wdata_o, e.wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        dbus_ack_i = 1'b0;
        mem_op_i   = '0;
    endtask

    task automatic push(input int c, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic mis, input logic [31:0] bad, input bit cwd, input bit cwdata);
        exp_t e;
        e.cyc = c; e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        e.mis = mis; e.bad = bad; e.chk_wd = cwd; e.chk_wdata = cwdata;
        q.push_back(e);
    endtask

    // Non-memory or misaligned instruction: one cycle latency, never stalls or requests.
    task automatic single(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic exp_mis);
        step();
        valid_i = 1'b1; mem_op_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        mem_wdata_i = 32'h5555_AAAA;
        if (exp_mis) push(cyc + 1, wd, 1'b0, 32'd0, 1'b1, wdata, 1'b0, 1'b0);
        else         push(cyc + 1, wd, wreg, wdata, 1'b0, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_stall", {31'd0, stall_o}, 32'd0);
        step();
        @(negedge clk);
        chk("single_no_req", {31'd0, dbus_req_o}, 32'd0);
    endtask

    // Aligned memory op with w wait cycles before the ack.
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] operand,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                           input int w, input logic we, input logic [3:0] be, input logic [31:0] bwdata,
                           input logic [31:0] exp_wdata);
        step();
        valid_i = 1'b1; mem_op_i = op; wd_i = wd; wreg_i = wreg; wdata_i = addr;
        mem_wdata_i = operand;
        push(cyc + w + 2, wd, we ? 1'b0 : wreg, exp_wdata, 1'b0, 32'd0, !we, 1'b1);
        @(negedge clk);
        chk("accept_stall", {31'd0, stall_o}, 32'd1);
        for (int i = 0; i <= w; i++) begin
            step();
            dbus_ack_i   = (i == w);
            dbus_rdata_i = (i == w) ? rdata : 32'hBAD0_BAD0;
            @(negedge clk);
            chk("bus_req", {31'd0, dbus_req_o}, 32'd1);
            chk("bus_we", {31'd0, dbus_we_o}, {31'd0, we});
            chk("bus_addr", dbus_addr_o, {addr[31:2], 2'b00});
            chk("bus_be", {28'd0, dbus_be_o}, {28'd0, be});
            chk("bus_wdata", dbus_wdata_o, bwdata);
            chk("bus_stall", {31'd0, stall_o}, (i == w) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
        chk("rst_addr", dbus_addr_o, 32'd0);
        chk("rst_be", {28'd0, dbus_be_o}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_wb_wdata", wb_wdata_o, 32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);

        // ALU pass-through and an unused op code treated as NOP.
        single(4'd0, 5'd5, 1'b1, 32'h1234_5678, 1'b0);
        single(4'd6, 5'd9, 1'b0, 32'hCAFE_0001, 1'b0);

        // LB/LBU byte 3 with three wait states.
        mem_txn(4'd1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h80AA_BBCC, 3, 1'b0, 4'b1000, 32'd0, 32'hFFFF_FF80);
        mem_txn(4'd2, 32'h0000_0103, 32'h0, 5'd8, 1'b1, 32'h80AA_BBCC, 3, 1'b0, 4'b1000, 32'd0, 32'h0000_0080);
        // Halfword loads, upper lane signed and lower lane unsigned.
        mem_txn(4'd3, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 32'h80AA_BBCC, 1, 1'b0, 4'b1100, 32'd0, 32'hFFFF_80AA);
        mem_txn(4'd4, 32'h0000_0100, 32'h0, 5'd10, 1'b1, 32'h1234_8001, 0, 1'b0, 4'b0011, 32'd0, 32'h0000_8001);
        // Stores: SH upper half, SB lane 1.
        mem_txn(4'd9, 32'h0000_2002, 32'hDEAD_BEEF, 5'd11, 1'b1, 32'h0, 1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        mem_txn(4'd8, 32'h0000_0021, 32'h1234_565A, 5'd12, 1'b1, 32'h0, 0, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'd0);

        // Misaligned accesses.
        single(4'd5, 5'd13, 1'b1, 32'h0000_1001, 1'b1);
        single(4'd9, 5'd14, 1'b1, 32'h0000_0003, 1'b1);

        // Back-to-back SW then LW, zero-wait; write-backs two cycles apart.
        mem_txn(4'd10, 32'h0000_0010, 32'h1122_3344, 5'd15, 1'b1, 32'h0, 0, 1'b1, 4'b1111, 32'h1122_3344, 32'd0);
        mem_txn(4'd5, 32'h0000_0010, 32'h0, 5'd16, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'd0, 32'hCAFE_F00D);

        // Reset during an outstanding transaction, then a stray ack.
        step();
        valid_i = 1'b1; mem_op_i = 4'd5; wd_i = 5'd17; wreg_i = 1'b1; wdata_i = 32'h40;
        step();
        @(negedge clk);
        chk("pre_rst_req", {31'd0, dbus_req_o}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req", {31'd0, dbus_req_o}, 32'd0);
        chk("abort_addr", dbus_addr_o, 32'd0);
        chk("abort_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("abort_stall", {31'd0, stall_o}, 32'd0);
        step();
        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'h7777_7777;
        @(negedge clk);
        chk("stray_ack_stall", {31'd0, stall_o}, 32'd0);
        step();
        @(negedge clk);
        chk("stray_ack_wb", {31'd0, wb_valid_o}, 32'd0);
        chk("stray_ack_req", {31'd0, dbus_req_o}, 32'd0);

        repeat (3) step();
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
